// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//   Write-back initiator for the register-file write port. Up to NSRC
//   producers (ALU, LSU, MUL/DIV, ...) present write requests with a
//   valid/ready handshake. One request is accepted per cycle in round-robin
//   order. It is then presented as a registered write on rf_we/rf_wa/rf_wd.
//   The write in flight is not yet visible in the register file, so it is
//   forwarded to the two read ports.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   src_valid  per-source request valid
//   src_ready  per-source accept (combinational, one-hot or zero)
//   src_addr   per-source destination register, slice [i*AW +: AW]
//   src_data   per-source write data, slice [i*XLEN +: XLEN]
//   rf_we      register-file write enable (registered)
//   rf_wa      register-file write address (registered)
//   rf_wd      register-file write data (registered)
//   qa1, qa2   register-file read addresses to compare for forwarding
//   fwd1_hit   qa1 matches the in-flight write
//   fwd2_hit   qa2 matches the in-flight write
//   fwd_data   forwarded data (equals rf_wd)
//   grant_cnt  saturating count of accepted requests (debug)
// -----------------------------------------------------------------------------
module wb_arbiter #(
   parameter int NSRC = 3,
   parameter int XLEN = 32,
   parameter int AW   = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NSRC-1:0]      src_valid,
   output logic [NSRC-1:0]      src_ready,
   input  logic [NSRC*AW-1:0]   src_addr,
   input  logic [NSRC*XLEN-1:0] src_data,
   output logic                 rf_we,
   output logic [AW-1:0]        rf_wa,
   output logic [XLEN-1:0]      rf_wd,
   input  logic [AW-1:0]        qa1,
   input  logic [AW-1:0]        qa2,
   output logic                 fwd1_hit,
   output logic                 fwd2_hit,
   output logic [XLEN-1:0]      fwd_data,
   output logic [15:0]          grant_cnt
);

   localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

   logic [PW-1:0]   rr_ptr_r;
   logic            rf_we_r;
   logic [AW-1:0]   rf_wa_r;
   logic [XLEN-1:0] rf_wd_r;
   logic [15:0]     grant_cnt_r;

   logic            found_s;
   logic            grant_s;
   logic [PW-1:0]   gidx_s;
   logic [PW-1:0]   nxt_ptr_s;
   logic [AW-1:0]   sel_addr_s;
   logic [XLEN-1:0] sel_data_s;
   logic [NSRC-1:0] src_ready_s;

   // Round-robin search: first valid source starting at rr_ptr, wrapping mod NSRC.
   always_comb begin
      int idx_v;
      idx_v      = 0;
      found_s    = 1'b0;
      gidx_s     = '0;
      sel_addr_s = '0;
      sel_data_s = '0;
      for (int k = 0; k < NSRC; k++) begin
         idx_v = (int'(rr_ptr_r) + k) % NSRC;
         if (!found_s && src_valid[idx_v]) begin
            found_s    = 1'b1;
            gidx_s     = idx_v[PW-1:0];
            sel_addr_s = src_addr[idx_v*AW +: AW];
            sel_data_s = src_data[idx_v*XLEN +: XLEN];
         end else begin
            found_s    = found_s;
         end
      end
   end

   // Grant qualification, one-hot ready and the pointer value after a grant.
   always_comb begin
      // Reset suppresses the grant so nothing is handed over in a reset cycle.
      grant_s = found_s && rst_n;
      for (int i = 0; i < NSRC; i++) begin
         src_ready_s[i] = grant_s && (int'(gidx_s) == i);
      end
      if (int'(gidx_s) == NSRC - 1) begin
         nxt_ptr_s = '0;
      end else begin
         nxt_ptr_s = gidx_s + PW'(1);
      end
   end

   // Output stage, round-robin pointer and grant counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rf_we_r     <= 1'b0;
         rf_wa_r     <= '0;
         rf_wd_r     <= '0;
         rr_ptr_r    <= '0;
         grant_cnt_r <= 16'd0;
      end else if (grant_s) begin
         // x0 writes are consumed with the enable low but still count as grants.
         rf_we_r  <= (sel_addr_s != '0);
         rf_wa_r  <= sel_addr_s;
         rf_wd_r  <= sel_data_s;
         rr_ptr_r <= nxt_ptr_s;
         if (grant_cnt_r != 16'hFFFF) begin
            grant_cnt_r <= grant_cnt_r + 16'd1;
         end else begin
            grant_cnt_r <= grant_cnt_r;
         end
      end else begin
         rf_we_r <= 1'b0;
      end
   end

   assign src_ready = src_ready_s;
   assign rf_we     = rf_we_r;
   assign rf_wa     = rf_wa_r;
   assign rf_wd     = rf_wd_r;
   assign grant_cnt = grant_cnt_r;
   assign fwd_data  = rf_wd_r;
   // x0 is hard-wired zero in the file, so it never takes a forwarded value.
   assign fwd1_hit  = rf_we_r && (qa1 != '0) && (qa1 == rf_wa_r);
   assign fwd2_hit  = rf_we_r && (qa2 != '0) && (qa2 == rf_wa_r);

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

   localparam int NSRC = 3;
   localparam int XLEN = 32;
   localparam int AW   = 5;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NSRC-1:0]      src_valid;
   logic [NSRC-1:0]      src_ready;
   logic [NSRC*AW-1:0]   src_addr;
   logic [NSRC*XLEN-1:0] src_data;
   logic                 rf_we;
   logic [AW-1:0]        rf_wa;
   logic [XLEN-1:0]      rf_wd;
   logic [AW-1:0]        qa1, qa2;
   logic                 fwd1_hit, fwd2_hit;
   logic [XLEN-1:0]      fwd_data;
   logic [15:0]          grant_cnt;

   always #5 clk = ~clk;

   wb_arbiter #(.NSRC(NSRC), .XLEN(XLEN), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .src_valid(src_valid), .src_ready(src_ready),
      .src_addr(src_addr), .src_data(src_data),
      .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
      .qa1(qa1), .qa2(qa2),
      .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd_data(fwd_data),
      .grant_cnt(grant_cnt)
   );

   typedef struct {
      int              cyc;
      logic [NSRC-1:0] rdy;
   } rdy_t;

   typedef struct {
      int              cyc;
      logic            we;
      logic [AW-1:0]   wa;
      logic [XLEN-1:0] wd;
      logic [15:0]     cnt;
   } out_t;

   rdy_t rq[$];
   out_t oq[$];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // stimulus-side view of each source's pending request
   logic            v[NSRC];
   logic [AW-1:0]   a[NSRC];
   logic [XLEN-1:0] d[NSRC];
   logic [NSRC-1:0] last_rdy;

   // reference model state: the architectural effect of accepted writes
   int              m_ptr;
   logic            m_we;
   logic [AW-1:0]   m_wa;
   logic [XLEN-1:0] m_wd;
   int              m_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Drive one cycle of inputs, predict the response, then advance past the edge.
   task automatic step(input logic rn, input logic [AW-1:0] q1, input logic [AW-1:0] q2);
      int              g;
      logic [NSRC-1:0] er;
      rdy_t            re;
      out_t            oe;
      rst_n = rn;
      qa1   = q1;
      qa2   = q2;
      for (int i = 0; i < NSRC; i++) begin
         src_valid[i]             = v[i];
         src_addr[i*AW +: AW]     = a[i];
         src_data[i*XLEN +: XLEN] = d[i];
      end
      // round-robin rule: first valid source counting up from the pointer
      g = -1;
      if (rn) begin
         for (int k = 0; k < NSRC; k++) begin
            if (g < 0 && v[(m_ptr + k) % NSRC]) g = (m_ptr + k) % NSRC;
         end
      end
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      if (!rn) begin
         m_we = 1'b0; m_wa = '0; m_wd = '0; m_ptr = 0; m_cnt = 0;
      end else if (g >= 0) begin
         m_we  = (a[g] != '0);
         m_wa  = a[g];
         m_wd  = d[g];
         m_ptr = (g + 1) % NSRC;
         m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      end else begin
         m_we = 1'b0;
      end
      re.cyc = cyc;
      re.rdy = er;
      rq.push_back(re);
      oe.cyc = cyc + 1;
      oe.we  = m_we;
      oe.wa  = m_wa;
      oe.wd  = m_wd;
      oe.cnt = 16'(m_cnt);
      oq.push_back(oe);
      last_rdy = er;
      @(posedge clk);
      #1;
   endtask

   // New request for sources that are idle or were just accepted; others hold.
   task automatic refresh(input int pct);
      for (int i = 0; i < NSRC; i++) begin
         if (!v[i] || last_rdy[i]) begin
            v[i] = ($urandom_range(99) < pct);
            a[i] = ($urandom_range(3) == 0) ? AW'(0) : AW'($urandom_range(7));
            d[i] = $urandom;
         end
      end
   endtask

   task automatic set_all(input logic val);
      for (int i = 0; i < NSRC; i++) v[i] = val;
   endtask

   // cycle counter
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // monitor: compares DUT outputs against scoreboard entries due this cycle
   initial begin
      rdy_t r;
      out_t o;
      out_t cur;
      logic have_cur;
      int   wait_cnt[NSRC];
      have_cur = 1'b0;
      for (int i = 0; i < NSRC; i++) wait_cnt[i] = 0;
      forever begin
         @(negedge clk);
         while (rq.size() > 0 && rq[0].cyc <= cyc) begin
            r = rq.pop_front();
            check("src_ready", 32'(src_ready), 32'(r.rdy));
         end
         while (oq.size() > 0 && oq[0].cyc <= cyc) begin
            o = oq.pop_front();
            cur = o;
            have_cur = 1'b1;
            check("rf_we", 32'(rf_we), 32'(o.we));
            check("rf_wa", 32'(rf_wa), 32'(o.wa));
            check("rf_wd", rf_wd, o.wd);
            check("grant_cnt", 32'(grant_cnt), 32'(o.cnt));
         end
         if (have_cur) begin
            check("fwd1_hit", 32'(fwd1_hit), 32'(cur.we && qa1 != '0 && qa1 == cur.wa));
            check("fwd2_hit", 32'(fwd2_hit), 32'(cur.we && qa2 != '0 && qa2 == cur.wa));
            check("fwd_data", fwd_data, cur.wd);
         end
         for (int i = 0; i < NSRC; i++) begin
            if (rst_n === 1'b1 && src_valid[i] === 1'b1 && src_ready[i] !== 1'b1)
               wait_cnt[i]++;
            else
               wait_cnt[i] = 0;
            if (rst_n === 1'b1 && src_valid[i] === 1'b1)
               check("fairness_wait_ok", 32'(wait_cnt[i] < NSRC), 32'd1);
         end
      end
   end

   initial begin
      rst_n = 1'b0; qa1 = '0; qa2 = '0;
      src_valid = '0; src_addr = '0; src_data = '0;
      last_rdy = '0;
      m_ptr = 0; m_we = 1'b0; m_wa = '0; m_wd = '0; m_cnt = 0;
      for (int i = 0; i < NSRC; i++) begin
         v[i] = 1'b0; a[i] = AW'(i + 1); d[i] = 32'(i) + 32'hA000_0000;
      end
      @(posedge clk);
      #1;

      // reset held with every source requesting, then release: source 0 first
      set_all(1'b1);
      step(1'b0, '0, '0);
      step(1'b0, '0, '0);
      step(1'b1, '0, '0);

      // single write to x5, then forward it on read port 1 only
      set_all(1'b0);
      v[0] = 1'b1; a[0] = 5'd5; d[0] = 32'hDEADBEEF;
      step(1'b1, '0, '0);
      v[0] = 1'b0;
      step(1'b1, 5'd5, 5'd6);
      step(1'b1, 5'd5, 5'd0);

      // contention from a fresh pointer: six back-to-back grants 0,1,2,0,1,2
      step(1'b0, '0, '0);
      set_all(1'b1);
      for (int n = 0; n < 6; n++) begin
         for (int i = 0; i < NSRC; i++) begin
            if (last_rdy[i]) d[i] = $urandom;
            a[i] = AW'(i + 1);
         end
         step(1'b1, AW'(n % 4), AW'(3));
      end
      set_all(1'b0);
      step(1'b1, 5'd1, 5'd3);

      // x0 write from source 1: accepted with the enable low, pointer moves to 2
      v[1] = 1'b1; a[1] = 5'd0; d[1] = 32'h0000_1234;
      step(1'b1, '0, '0);
      v[1] = 1'b0;
      step(1'b1, 5'd0, 5'd0);

      // mid-operation reset right after a grant to source 2
      v[2] = 1'b1; a[2] = 5'd9; d[2] = 32'h2222_0002;
      step(1'b1, '0, '0);
      set_all(1'b1);
      step(1'b0, 5'd9, '0);
      step(1'b1, 5'd9, '0);
      set_all(1'b0);
      step(1'b1, 5'd1, '0);

      // randomized traffic with occasional resets
      for (int n = 0; n < 400; n++) begin
         refresh((n < 200) ? 50 : 90);
         step(($urandom_range(99) != 0), AW'($urandom_range(7)), AW'($urandom_range(7)));
      end

      set_all(1'b0);
      step(1'b1, '0, '0);
      step(1'b1, '0, '0);
      @(negedge clk);
      #1;
      if (rq.size() != 0 || oq.size() != 0) begin
         check("scoreboard_drained", 32'(rq.size() + oq.size()), 32'd0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
